// File: rtl/paula_floppy_pkg.sv
// Shared definitions for the Paula floppy drive-ID generator.
//   - id_state_e : per-drive ID state machine encoding (2 bits)
//   - ID_*       : standard Amiga drive identification words
package paula_floppy_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_ON  = 2'd0,  // waiting for the drive motor to be switched on
        ST_WAIT_OFF = 2'd1,  // motor on; waiting for it to be switched off
        ST_ENABLE   = 2'd2   // motor off again: each /SEL pulse shifts out one ID bit
    } id_state_e;

    localparam logic [31:0] ID_DD35  = 32'hFFFF_FFFF;
    localparam logic [31:0] ID_HD35  = 32'hAAAA_AAAA;
    localparam logic [31:0] ID_DD525 = 32'h5555_5555;
    localparam logic [31:0] ID_NONE  = 32'h0000_0000;

endpackage

// File: rtl/paula_floppy_drive_id_channel.sv
// One drive channel of the floppy drive-ID generator.
// Detects /SEL edges, latches the motor state on the falling edge, runs the
// ID state machine and produces this drive's registered /RDY contribution.
// All state advances only on clk7_en.
//
// Ports:
//   clk, _reset  : clock, asynchronous active-low reset
//   clk7_en      : 7 MHz clock enable
//   _motor       : shared /MTR line, active low
//   _sel         : this drive's /SEL, active low
//   present      : 1 = drive connected
//   drive_id     : ID word, shifted out MSB first
//   motor_on     : latched motor state
//   id_active    : 1 while in ST_ENABLE
//   rdy_n        : registered /RDY contribution (wired-AND in the top)
module paula_floppy_id_channel
    import paula_floppy_pkg::*;
#(
    parameter int ID_WIDTH  = 32,
    parameter int ID_REPEAT = 1
) (
    input  logic                clk,
    input  logic                _reset,
    input  logic                clk7_en,
    input  logic                _motor,
    input  logic                _sel,
    input  logic                present,
    input  logic [ID_WIDTH-1:0] drive_id,
    output logic                motor_on,
    output logic                id_active,
    output logic                rdy_n
);

    localparam int                CNT_W    = (ID_WIDTH > 1) ? $clog2(ID_WIDTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ID_WIDTH - 1);

    id_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_del_q, sel_del_d;
    logic             motor_on_q, motor_on_d;
    logic             bit_q, bit_d;
    logic             armed_q, armed_d;
    logic             rdy_q, rdy_d;

    logic sel_fall;
    logic sel_rise;

    assign sel_fall = !_sel && sel_del_q;
    assign sel_rise = _sel && !sel_del_q;

    // State register.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values computed before this edge regardless of block order.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q    <= ST_WAIT_ON;
            cnt_q      <= '0;
            sel_del_q  <= 1'b1;
            motor_on_q <= 1'b0;
            bit_q      <= 1'b0;
            armed_q    <= 1'b0;
            rdy_q      <= 1'b1;
        end else if (clk7_en) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_del_q  <= sel_del_d;
            motor_on_q <= motor_on_d;
            bit_q      <= bit_d;
            armed_q    <= armed_d;
            rdy_q      <= rdy_d;
        end
    end

    // Next-state logic.
    // NOTE: every signal gets a default before the case, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        armed_d   = armed_q;
        sel_del_d = _sel;

        motor_on_d = motor_on_q;
        if (!present) begin
            motor_on_d = 1'b0;
        end else if (sel_fall) begin
            motor_on_d = !_motor;
        end

        case (state_q)
            ST_WAIT_ON: begin
                if (motor_on_q) begin
                    state_d = ST_WAIT_OFF;
                end
            end
            ST_WAIT_OFF: begin
                if (!motor_on_q) begin
                    state_d = ST_ENABLE;
                    cnt_d   = '0;
                    bit_d   = 1'b0;
                    armed_d = 1'b0;
                end
            end
            ST_ENABLE: begin
                if (sel_fall) begin
                    if (!_motor) begin
                        // Motor switched back on: abandon the read, keep cnt.
                        state_d = ST_WAIT_OFF;
                        bit_d   = 1'b0;
                        armed_d = 1'b0;
                    end else begin
                        bit_d   = drive_id[CNT_LAST - cnt_q];
                        armed_d = 1'b1;
                    end
                end else if (sel_rise) begin
                    bit_d = 1'b0;
                    // Only a pulse that actually emitted a bit advances the
                    // counter; the rising edge of the pulse that switched the
                    // motor off lands here too and must not skip bit 0.
                    if (armed_q) begin
                        armed_d = 1'b0;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d = '0;
                            if (ID_REPEAT == 0) begin
                                state_d = ST_WAIT_ON;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_WAIT_ON;
            end
        endcase
    end

    // Output logic: /RDY contribution is registered, so it appears one tick
    // after the tick that saw the /SEL edge.
    always_comb begin
        id_active = (state_q == ST_ENABLE);
        if (!present) begin
            rdy_d = 1'b1;
        end else if (state_q == ST_ENABLE) begin
            rdy_d = !(bit_q && !_sel);
        end else begin
            rdy_d = !(!_sel && motor_on_q);
        end
    end

    assign motor_on = motor_on_q;
    assign rdy_n    = rdy_q;

endmodule

// File: rtl/paula_floppy_drive_id.sv
// Multi-drive floppy ID generator between CIA-B (/MTR, /SELx) and CIA-A /RDY.
// One paula_floppy_id_channel per drive; the top slices drive_id and forms
// the open-collector wired-AND of the per-drive /RDY contributions.
//
// Ports:
//   clk, _reset : clock, asynchronous active-low reset
//   clk7_en     : 7 MHz clock enable
//   _motor      : shared /MTR, active low
//   _sel        : per-drive /SEL, active low
//   present     : per-drive connected flag
//   drive_id    : ID words, drive i at [i*ID_WIDTH +: ID_WIDTH]
//   motor_on    : latched motor state per drive
//   id_active   : per-drive ID mode flag
//   _rdy        : combined /RDY, active low
module paula_floppy_drive_id
    import paula_floppy_pkg::*;
#(
    parameter int NUM_DRIVES = 4,
    parameter int ID_WIDTH   = 32,
    parameter int ID_REPEAT  = 1
) (
    input  logic                           clk,
    input  logic                           _reset,
    input  logic                           clk7_en,
    input  logic                           _motor,
    input  logic [NUM_DRIVES-1:0]          _sel,
    input  logic [NUM_DRIVES-1:0]          present,
    input  logic [NUM_DRIVES*ID_WIDTH-1:0] drive_id,
    output logic [NUM_DRIVES-1:0]          motor_on,
    output logic [NUM_DRIVES-1:0]          id_active,
    output logic                           _rdy
);

    logic [NUM_DRIVES-1:0] rdy_n;

    for (genvar i = 0; i < NUM_DRIVES; i++) begin : g_ch
        paula_floppy_id_channel #(
            .ID_WIDTH  (ID_WIDTH),
            .ID_REPEAT (ID_REPEAT)
        ) u_ch (
            .clk       (clk),
            ._reset    (_reset),
            .clk7_en   (clk7_en),
            ._motor    (_motor),
            ._sel      (_sel[i]),
            .present   (present[i]),
            .drive_id  (drive_id[i*ID_WIDTH +: ID_WIDTH]),
            .motor_on  (motor_on[i]),
            .id_active (id_active[i]),
            .rdy_n     (rdy_n[i])
        );
    end

    assign _rdy = &rdy_n;

endmodule

// File: tb/tb_paula_floppy_drive_id.sv
// Bench for paula_floppy_drive_id: a 4-drive/32-bit/repeat instance plus two
// 1-drive/8-bit instances (repeat on and off) sharing a separate /SEL line.
module tb_paula_floppy_drive_id;
    import paula_floppy_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         clk7_en;
    logic         motor_n;
    logic [3:0]   a_sel;
    logic [3:0]   a_present;
    logic [127:0] a_id;
    logic [3:0]   a_motor_on;
    logic [3:0]   a_id_active;
    logic         a_rdy;

    logic [0:0]   s_sel;
    logic [0:0]   b_motor_on, b_id_active, c_motor_on, c_id_active;
    logic         b_rdy, c_rdy;

    logic samp_a, samp_b, samp_c;
    logic q_a[$];
    logic q_b[$];
    logic q_c[$];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    paula_floppy_drive_id #(.NUM_DRIVES(4), .ID_WIDTH(32), .ID_REPEAT(1)) dut_a (
        .clk(clk), ._reset(reset_n), .clk7_en(clk7_en), ._motor(motor_n),
        ._sel(a_sel), .present(a_present), .drive_id(a_id),
        .motor_on(a_motor_on), .id_active(a_id_active), ._rdy(a_rdy)
    );

    paula_floppy_drive_id #(.NUM_DRIVES(1), .ID_WIDTH(8), .ID_REPEAT(1)) dut_b (
        .clk(clk), ._reset(reset_n), .clk7_en(clk7_en), ._motor(motor_n),
        ._sel(s_sel), .present(1'b1), .drive_id(8'hC3),
        .motor_on(b_motor_on), .id_active(b_id_active), ._rdy(b_rdy)
    );

    paula_floppy_drive_id #(.NUM_DRIVES(1), .ID_WIDTH(8), .ID_REPEAT(0)) dut_c (
        .clk(clk), ._reset(reset_n), .clk7_en(clk7_en), ._motor(motor_n),
        ._sel(s_sel), .present(1'b1), .drive_id(8'hC3),
        .motor_on(c_motor_on), .id_active(c_id_active), ._rdy(c_rdy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One /SEL pulse: lines low for 4 clocks (outputs sampled after 3 ticks),
    // then high for 4 clocks.
    task automatic pulse(input logic [3:0] a_low, input logic s_low, input logic mot_n);
        @(negedge clk);
        motor_n = mot_n;
        a_sel   = ~a_low;
        s_sel   = {~s_low};
        repeat (3) @(negedge clk);
        samp_a = a_rdy;
        samp_b = b_rdy;
        samp_c = c_rdy;
        @(negedge clk);
        a_sel = 4'hF;
        s_sel = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Motor on then motor off on drive d: enters ID mode if present.
    task automatic enter_id(input int d, input logic exp_present);
        pulse(4'b1 << d, 1'b0, 1'b0);
        check($sformatf("motor_on[%0d] after motor-on select", d), 32'(a_motor_on[d]), 32'(exp_present));
        check($sformatf("rdy d%0d motor-on select", d), 32'(samp_a), 32'(!exp_present));
        pulse(4'b1 << d, 1'b0, 1'b1);
        check($sformatf("id_active[%0d] after motor-off select", d), 32'(a_id_active[d]), 32'(exp_present));
    endtask

    // Read nbits from drive d on dut_a; expected word right-aligned.
    task automatic read_a(input int d, input int nbits, input logic [31:0] exp_word,
                          input logic exp_active, output logic [31:0] got);
        logic e;
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            q_a.push_back(!exp_word[nbits-1-i]);
            pulse(4'b1 << d, 1'b0, 1'b1);
            e = q_a.pop_front();
            check($sformatf("rdy d%0d bit%0d", d, i), 32'(samp_a), 32'(e));
            check($sformatf("id_active[%0d] bit%0d", d, i), 32'(a_id_active[d]), 32'(exp_active));
            got = {got[30:0], !samp_a};
        end
    endtask

    typedef struct {
        int          drive;
        logic        present;
        logic [31:0] id;
        logic [31:0] exp_word;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[3];
        logic [31:0] got, got_b, got_c;
        logic        e;

        reset_n   = 1'b0;
        clk7_en   = 1'b1;
        motor_n   = 1'b1;
        a_sel     = 4'hF;
        s_sel     = 1'b1;
        a_present = 4'b0011;
        // Drive 2 is programmed but absent: it must read as zero.
        a_id = {ID_NONE, ID_DD35, ID_DD525, ID_HD35};

        vecs[0] = '{drive: 0, present: 1'b1, id: ID_HD35,  exp_word: ID_HD35};
        vecs[1] = '{drive: 1, present: 1'b1, id: ID_DD525, exp_word: ID_DD525};
        vecs[2] = '{drive: 2, present: 1'b0, id: ID_DD35,  exp_word: ID_NONE};

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("reset _rdy", 32'(a_rdy), 32'd1);
        check("reset motor_on", 32'(a_motor_on), 32'd0);
        check("reset id_active", 32'(a_id_active), 32'd0);

        // 8-bit instances: repeat keeps reading, no-repeat stops after 8.
        pulse(4'b0, 1'b1, 1'b0);
        pulse(4'b0, 1'b1, 1'b1);
        check("b id_active entry", 32'(b_id_active), 32'd1);
        check("c id_active entry", 32'(c_id_active), 32'd1);
        got_b = '0;
        got_c = '0;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] w;
            w = 8'hC3;
            q_b.push_back(!w[7 - (i % 8)]);
            q_c.push_back((i < 8) ? !w[7 - i] : 1'b1);
            pulse(4'b0, 1'b1, 1'b1);
            e = q_b.pop_front();
            check($sformatf("b rdy pulse%0d", i), 32'(samp_b), 32'(e));
            e = q_c.pop_front();
            check($sformatf("c rdy pulse%0d", i), 32'(samp_c), 32'(e));
            got_b = {got_b[30:0], !samp_b};
            got_c = {got_c[30:0], !samp_c};
            if (i == 7) begin
                check("c id_active after pulse 8", 32'(c_id_active), 32'd0);
                check("b id_active after pulse 8", 32'(b_id_active), 32'd1);
            end
        end
        check("b word x2", got_b, 32'h0000_C3C3);
        check("c word", got_c, 32'h0000_C300);
        check("b id_active after 16", 32'(b_id_active), 32'd1);

        // Table-driven reads on the 4-drive instance.
        for (int v = 0; v < 3; v++) begin
            a_id[vecs[v].drive*32 +: 32] = vecs[v].id;
            enter_id(vecs[v].drive, vecs[v].present);
        end
        for (int v = 0; v < 3; v++) begin
            read_a(vecs[v].drive, 32, vecs[v].exp_word, vecs[v].present, got);
            check($sformatf("word drive %0d", vecs[v].drive), got, vecs[v].exp_word);
        end
        check("motor_on[2] absent", 32'(a_motor_on[2]), 32'd0);

        // Interleaved reads of drives 0 and 1; drive 0's new ID applies at once.
        a_id[31:0] = ID_DD35;
        got   = '0;
        got_b = '0;
        for (int i = 0; i < 32; i++) begin
            q_a.push_back(!ID_DD35[31-i]);
            pulse(4'b0001, 1'b0, 1'b1);
            e = q_a.pop_front();
            check($sformatf("il d0 bit%0d", i), 32'(samp_a), 32'(e));
            got = {got[30:0], !samp_a};
            q_a.push_back(!ID_DD525[31-i]);
            pulse(4'b0010, 1'b0, 1'b1);
            e = q_a.pop_front();
            check($sformatf("il d1 bit%0d", i), 32'(samp_a), 32'(e));
            got_b = {got_b[30:0], !samp_a};
        end
        check("il word d0", got, ID_DD35);
        check("il word d1", got_b, ID_DD525);

        // Abort at cnt=5 by selecting with the motor line low.
        a_id[31:0] = 32'h1234_5678;
        read_a(0, 5, 32'h1234_5678 >> 27, 1'b1, got);
        check("abort partial word", got, 32'h0000_0002);
        pulse(4'b0001, 1'b0, 1'b0);
        check("abort rdy (motor ready)", 32'(samp_a), 32'd0);
        check("abort motor_on[0]", 32'(a_motor_on[0]), 32'd1);
        check("abort id_active[0]", 32'(a_id_active[0]), 32'd0);
        pulse(4'b0001, 1'b0, 1'b1);
        check("abort motor off rdy", 32'(samp_a), 32'd1);
        check("abort motor off motor_on[0]", 32'(a_motor_on[0]), 32'd0);
        check("abort re-enter id_active[0]", 32'(a_id_active[0]), 32'd1);
        read_a(0, 32, 32'h1234_5678, 1'b1, got);
        check("after abort word", got, 32'h1234_5678);

        // Clock enable held low: a would-be abort pulse must change nothing.
        clk7_en = 1'b0;
        pulse(4'b0001, 1'b0, 1'b0);
        check("gated rdy", 32'(samp_a), 32'd1);
        check("gated motor_on[0]", 32'(a_motor_on[0]), 32'd0);
        check("gated id_active[0]", 32'(a_id_active[0]), 32'd1);
        clk7_en = 1'b1;
        repeat (2) @(negedge clk);
        read_a(0, 32, 32'h1234_5678, 1'b1, got);
        check("after gating word", got, 32'h1234_5678);

        // Reset in the middle of a read, then a full read from bit 0.
        read_a(0, 7, 32'h1234_5678 >> 25, 1'b1, got);
        @(negedge clk);
        a_sel = 4'b1110;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid-read reset _rdy", 32'(a_rdy), 32'd1);
        check("mid-read reset motor_on", 32'(a_motor_on), 32'd0);
        check("mid-read reset id_active", 32'(a_id_active), 32'd0);
        @(negedge clk);
        a_sel   = 4'hF;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        enter_id(0, 1'b1);
        read_a(0, 32, 32'h1234_5678, 1'b1, got);
        check("after reset word", got, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
